// File: rtl/seg_shift_rx_if.sv
// Bus between the segment shift-register link (four serial lines) and the
// receiver's reassembled-frame outputs.
interface seg_shift_rx_if #(
    parameter int FRAME_BITS = 64
);
    logic                  seg_clk;
    logic                  seg_do;
    logic                  seg_clr;
    logic                  seg_pen;
    logic [FRAME_BITS-1:0] frame;
    logic                  frame_valid;
    logic                  frame_err;
    logic [7:0]            frame_cnt;
    logic [31:0]           digits;
    logic [7:0]            digit_ok;

    modport master (
        output seg_clk, seg_do, seg_clr, seg_pen,
        input  frame, frame_valid, frame_err, frame_cnt, digits, digit_ok
    );

    modport slave (
        input  seg_clk, seg_do, seg_clr, seg_pen,
        output frame, frame_valid, frame_err, frame_cnt, digits, digit_ok
    );
endinterface

// File: rtl/seg_shift_rx.sv
// Receiver for the 7-segment shift-register link: synchronizes the lines,
// rebuilds each frame on seg_pen and flags bad bit counts. Optional segment
// decode is built only when SEG_DECODE_EN is defined.
module seg_shift_rx #(
    parameter int FRAME_BITS  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    seg_shift_rx_if.slave bus
);
    // Line order inside each sync stage: {pen, clr_n, do, clk}
    localparam int LINES = 4;

    logic [LINES-1:0]      r_sync [SYNC_STAGES];
    logic [LINES-1:0]      w_last;
    logic                  r_prev_clk;
    logic                  r_prev_pen;
    logic [1:0]            r_arm;
    logic                  w_armed;
    logic                  w_clk_rise;
    logic                  w_pen_rise;
    logic                  w_clr;
    logic                  w_do;
    logic                  w_err;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] w_latch_src;
    logic [6:0]            r_bit_cnt;
    logic                  r_latch_p1;
    logic [FRAME_BITS-1:0] r_frame;
    logic                  r_frame_valid;
    logic                  r_frame_err;
    logic [7:0]            r_frame_cnt;

    // Stage p0: synchronizers, edge history and post-reset arming
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_prev_clk <= 1'b0;
            r_prev_pen <= 1'b0;
            r_arm      <= 2'd0;
        end else begin
            r_sync[0] <= {bus.seg_pen, bus.seg_clr, bus.seg_do, bus.seg_clk};
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_prev_clk <= w_last[0];
            r_prev_pen <= w_last[3];
            if (!w_armed) r_arm <= r_arm + 2'd1;
        end
    end

    assign w_last     = r_sync[SYNC_STAGES-1];
    assign w_armed    = (r_arm == 2'd3);
    assign w_clk_rise = w_armed & w_last[0] & ~r_prev_clk;
    assign w_pen_rise = w_armed & w_last[3] & ~r_prev_pen;
    assign w_clr      = ~w_last[2];
    assign w_do       = w_last[1];

    // Stage p1: shift register, bit count; pen edge delayed one cycle so a
    // same-cycle shift is already in r_shift when the frame is latched
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_bit_cnt  <= 7'd0;
            r_latch_p1 <= 1'b0;
        end else begin
            r_latch_p1 <= w_pen_rise;
            if (w_clr) begin
                r_shift   <= '0;
                r_bit_cnt <= 7'd0;
            end else begin
                if (w_clk_rise) r_shift <= {r_shift[FRAME_BITS-2:0], w_do};
                if (r_latch_p1)
                    r_bit_cnt <= w_clk_rise ? 7'd1 : 7'd0;
                else if (w_clk_rise && r_bit_cnt != 7'd127)
                    r_bit_cnt <= r_bit_cnt + 7'd1;
            end
        end
    end

    assign w_latch_src = w_clr ? '0 : r_shift;
    assign w_err       = w_clr || (int'(r_bit_cnt) != FRAME_BITS);

    // Stage p2: latched frame outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_cnt   <= 8'd0;
        end else begin
            r_frame_valid <= r_latch_p1;
            if (r_latch_p1) begin
                r_frame     <= w_latch_src;
                r_frame_err <= w_err;
                if (!w_err) r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign bus.frame       = r_frame;
    assign bus.frame_valid = r_frame_valid;
    assign bus.frame_err   = r_frame_err;
    assign bus.frame_cnt   = r_frame_cnt;

`ifdef SEG_DECODE_EN
    // Bytes are {dp,g,f,e,d,c,b,a} active-low; dp is ignored
    function automatic logic [4:0] f_seg_decode(input logic [7:0] b_in);
        logic [6:0] seg;
        logic [4:0] res;
        seg = ~b_in[6:0];
        res = 5'd0;
        case (seg)
            7'h3F: res = 5'h10;
            7'h06: res = 5'h11;
            7'h5B: res = 5'h12;
            7'h4F: res = 5'h13;
            7'h66: res = 5'h14;
            7'h6D: res = 5'h15;
            7'h7D: res = 5'h16;
            7'h07: res = 5'h17;
            7'h7F: res = 5'h18;
            7'h6F: res = 5'h19;
            7'h77: res = 5'h1A;
            7'h7C: res = 5'h1B;
            7'h39: res = 5'h1C;
            7'h5E: res = 5'h1D;
            7'h79: res = 5'h1E;
            7'h71: res = 5'h1F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    logic [4:0]  w_dec [8];
    logic [31:0] r_digits;
    logic [7:0]  r_digit_ok;

    for (genvar k = 0; k < 8; k++) begin : g_dec
        if (8*k + 8 <= FRAME_BITS) begin : g_byte
            assign w_dec[k] = f_seg_decode(w_latch_src[8*k +: 8]);
        end else begin : g_none
            assign w_dec[k] = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digits   <= '0;
            r_digit_ok <= '0;
        end else if (r_latch_p1) begin
            for (int k = 0; k < 8; k++) begin
                r_digits[4*k +: 4] <= w_dec[k][3:0];
                r_digit_ok[k]      <= w_dec[k][4];
            end
        end
    end

    assign bus.digits   = r_digits;
    assign bus.digit_ok = r_digit_ok;
`else
    assign bus.digits   = '0;
    assign bus.digit_ok = '0;
`endif
endmodule

// File: tb/tb_seg_shift_rx.sv
// Bench for seg_shift_rx: a 64-bit receiver for the directed frames and an
// 8-bit receiver for the frame-counter wrap, both checked against a bit-level model.
module tb_seg_shift_rx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic b_clk = 1'b0, b_do = 1'b0, b_clr = 1'b1, b_pen = 1'b0;
    logic sel = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pulses_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    seg_shift_rx_if #(.FRAME_BITS(64)) if_a ();
    seg_shift_rx_if #(.FRAME_BITS(8))  if_b ();

    assign if_a.seg_clk = sel ? 1'b0 : b_clk;
    assign if_a.seg_do  = sel ? 1'b0 : b_do;
    assign if_a.seg_clr = sel ? 1'b1 : b_clr;
    assign if_a.seg_pen = sel ? 1'b0 : b_pen;
    assign if_b.seg_clk = sel ? b_clk : 1'b0;
    assign if_b.seg_do  = sel ? b_do  : 1'b0;
    assign if_b.seg_clr = sel ? b_clr : 1'b1;
    assign if_b.seg_pen = sel ? b_pen : 1'b0;

    seg_shift_rx #(.FRAME_BITS(64), .SYNC_STAGES(2)) u_dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave));
    seg_shift_rx #(.FRAME_BITS(8), .SYNC_STAGES(2)) u_dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave));

    typedef struct {
        int          cyc;
        logic [63:0] frame;
        logic        err;
        logic [7:0]  cnt;
        logic [31:0] digits;
        logic [7:0]  ok;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        cur [2];
    logic [63:0] m_shift [2];
    int          m_cnt [2];
    int          m_fcnt [2];

    function automatic exp_t exp_zero();
        exp_t z;
        z.cyc = 0; z.frame = '0; z.err = 1'b0; z.cnt = '0; z.digits = '0; z.ok = '0;
        return z;
    endfunction

`ifdef SEG_DECODE_EN
    function automatic logic [4:0] m_decode(input logic [7:0] b);
        logic [6:0] pat [16];
        logic [6:0] lit;
        pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        lit = ~b[6:0];
        for (int i = 0; i < 16; i++)
            if (lit == pat[i]) return {1'b1, i[3:0]};
        return 5'd0;
    endfunction
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    task automatic m_bit(input logic b);
        int d = int'(sel);
        logic [63:0] mask = (d == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFF;
        m_shift[d] = ((m_shift[d] << 1) | 64'(b)) & mask;
        m_cnt[d]++;
    endtask

    task automatic m_clear();
        int d = int'(sel);
        m_shift[d] = '0;
        m_cnt[d] = 0;
    endtask

    task automatic m_latch(input int at);
        int d = int'(sel);
        int nb = (d == 0) ? 64 : 8;
        exp_t e = exp_zero();
        e.cyc   = at;
        e.frame = m_shift[d];
        e.err   = (m_cnt[d] != nb);
        if (!e.err) m_fcnt[d] = (m_fcnt[d] + 1) % 256;
        e.cnt = 8'(m_fcnt[d]);
`ifdef SEG_DECODE_EN
        for (int k = 0; k < nb / 8 && k < 8; k++) begin
            logic [4:0] dec;
            dec = m_decode(e.frame[8*k +: 8]);
            e.digits[4*k +: 4] = dec[3:0];
            e.ok[k] = dec[4];
        end
`endif
        m_cnt[d] = 0;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic m_reset();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            cur[d] = exp_zero();
            m_shift[d] = '0;
            m_cnt[d] = 0;
            m_fcnt[d] = 0;
        end
    endtask

    // ---------------- compare process ----------------
    task automatic check_dut(input int d);
        logic v, e;
        logic [63:0] f;
        logic [7:0] c, ok;
        logic [31:0] dg;
        exp_t x;
        int have;
        if (d == 0) begin
            v = if_a.frame_valid; f = if_a.frame; e = if_a.frame_err;
            c = if_a.frame_cnt; dg = if_a.digits; ok = if_a.digit_ok;
            have = q0.size();
            if (have > 0) x = q0[0];
        end else begin
            v = if_b.frame_valid; f = 64'(if_b.frame); e = if_b.frame_err;
            c = if_b.frame_cnt; dg = if_b.digits; ok = if_b.digit_ok;
            have = q1.size();
            if (have > 0) x = q1[0];
        end
        if (have > 0 && x.cyc <= cyc) begin
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            cur[d] = x;
            chk($sformatf("dut%0d valid@%0d", d, x.cyc), 64'(v), 64'd1);
        end else begin
            chk($sformatf("dut%0d idle@%0d", d, cyc), 64'(v), 64'd0);
        end
        chk($sformatf("dut%0d frame@%0d", d, cyc), f, cur[d].frame);
        chk($sformatf("dut%0d err@%0d", d, cyc), 64'(e), 64'(cur[d].err));
        chk($sformatf("dut%0d cnt@%0d", d, cyc), 64'(c), 64'(cur[d].cnt));
        chk($sformatf("dut%0d digits@%0d", d, cyc), 64'(dg), 64'(cur[d].digits));
        chk($sformatf("dut%0d ok@%0d", d, cyc), 64'(ok), 64'(cur[d].ok));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check_dut(0);
            check_dut(1);
            if (if_b.frame_valid) pulses_b++;
        end
    end

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        b_do = b;
        step(2);
        b_clk = 1'b1;
        m_bit(b);
        step(4);
        b_clk = 1'b0;
        step(2);
    endtask

    task automatic send_word(input logic [63:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic latch();
        b_pen = 1'b1;
        m_latch(cyc + 4);
        step(4);
        b_pen = 1'b0;
        step(4);
    endtask

    task automatic clk_pen(input logic b);
        b_do = b;
        step(2);
        b_clk = 1'b1;
        b_pen = 1'b1;
        m_bit(b);
        m_latch(cyc + 4);
        step(4);
        b_clk = 1'b0;
        b_pen = 1'b0;
        step(4);
    endtask

    localparam logic [63:0] W1 = 64'hC0F9_A4B0_9992_9BF8;
    localparam logic [63:0] W2 = 64'h0123_4567_89AB_CDEF;

    initial begin
        m_reset();
        reset = 1'b1;
        step(5);
        reset = 1'b0;
        step(1);
        chk("reset frame", if_a.frame, 64'd0);
        chk("reset cnt", 64'(if_a.frame_cnt), 64'd0);
        chk("reset valid", 64'(if_a.frame_valid), 64'd0);
        step(4);

        // full good frame
        send_word(W1, 64);
        latch();
        chk("t1 frame", if_a.frame, 64'hC0F9_A4B0_9992_9BF8);
        chk("t1 err", 64'(if_a.frame_err), 64'd0);
        chk("t1 cnt", 64'(if_a.frame_cnt), 64'd1);
`ifdef SEG_DECODE_EN
        chk("t1 digits", 64'(if_a.digits), 64'h0123_4507);
        chk("t1 digit_ok", 64'(if_a.digit_ok), 64'hFD);
`else
        chk("t1 digits", 64'(if_a.digits), 64'd0);
        chk("t1 digit_ok", 64'(if_a.digit_ok), 64'd0);
`endif

        // short and long frames
        send_word(W2, 63);
        latch();
        chk("t2 short err", 64'(if_a.frame_err), 64'd1);
        chk("t2 short cnt", 64'(if_a.frame_cnt), 64'd1);
        send_bit(1'b1);
        send_word(W2, 64);
        latch();
        chk("t2 long frame", if_a.frame, W2);
        chk("t2 long err", 64'(if_a.frame_err), 64'd1);

        // clear discards a partial frame
        send_word(W1, 30);
        b_clr = 1'b0;
        m_clear();
        step(4);
        b_clr = 1'b1;
        step(4);
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 64);
        latch();
        chk("t3 frame", if_a.frame, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3 err", 64'(if_a.frame_err), 64'd0);
        chk("t3 cnt", 64'(if_a.frame_cnt), 64'd2);

        // clock and pen rising together
        send_word(W2 >> 1, 63);
        clk_pen(W2[0]);
        chk("t4 frame", if_a.frame, W2);
        chk("t4 err", 64'(if_a.frame_err), 64'd0);
        chk("t4 cnt", 64'(if_a.frame_cnt), 64'd3);

        // clear low while pen rises
        b_clr = 1'b0;
        b_pen = 1'b1;
        m_clear();
        m_latch(cyc + 4);
        step(4);
        b_clr = 1'b1;
        b_pen = 1'b0;
        step(4);
        chk("t5 frame", if_a.frame, 64'd0);
        chk("t5 err", 64'(if_a.frame_err), 64'd1);
        chk("t5 cnt", 64'(if_a.frame_cnt), 64'd3);

        // reset mid-frame with seg_clk held high through release
        send_word(W1, 40);
        b_do = 1'b1;
        b_clk = 1'b1;
        reset = 1'b1;
        m_reset();
        step(5);
        reset = 1'b0;
        step(1);
        chk("t6 frame", if_a.frame, 64'd0);
        chk("t6 valid", 64'(if_a.frame_valid), 64'd0);
        chk("t6 err", 64'(if_a.frame_err), 64'd0);
        chk("t6 cnt", 64'(if_a.frame_cnt), 64'd0);
        chk("t6 digits", 64'(if_a.digits), 64'd0);
        chk("t6 digit_ok", 64'(if_a.digit_ok), 64'd0);
        step(10);
        b_clk = 1'b0;
        step(4);
        send_word(W2, 64);
        latch();
        chk("t6 after frame", if_a.frame, W2);
        chk("t6 after err", 64'(if_a.frame_err), 64'd0);
        chk("t6 after cnt", 64'(if_a.frame_cnt), 64'd1);

        // 256 good frames on the 8-bit receiver
        sel = 1'b1;
        step(4);
        for (int i = 0; i < 256; i++) begin
            send_word(64'(i), 8);
            latch();
            if (i == 254) chk("t7 cnt 255", 64'(if_b.frame_cnt), 64'd255);
        end
        chk("t7 cnt wrap", 64'(if_b.frame_cnt), 64'd0);
        chk("t7 last frame", 64'(if_b.frame), 64'hFF);
        chk("t7 pulses", 64'(pulses_b), 64'd256);

        step(10);
        chk("pending dut0", 64'(q0.size()), 64'd0);
        chk("pending dut1", 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
